mips_mul_div: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).

---
 rtl/mips_mul_div.sv | 200 ++++++++++++++++++++
 tb/tb_mips_mul_div.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : mips_mul_div
// Description : Iterative multiply/divide unit with HI/LO registers for the
//               single-cycle MIPS (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//               Radix-2 shift-add multiply, restoring shift-subtract divide,
//               STEPS_PER_CYCLE iterations per clock, sign fix-up at the end.
//               Optional macro MULDIV_FAST_ZERO_EN: zero multiply operand or
//               zero divisor goes straight to the fix-up state.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mul_div #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hiWrite_in,
  input  logic             loWrite_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int c_n     = WIDTH / STEPS_PER_CYCLE;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;      // product high half / partial remainder
  logic [WIDTH-1:0]   qr_q, qr_d;        // multiplier -> product low half / quotient
  logic [WIDTH-1:0]   m_q, m_d;          // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d; // negate product / quotient at fix-up
  logic               neg_hi_q, neg_hi_d; // negate remainder at fix-up
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   w_acc, w_qr;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic               w_signed;

  // Datapath: STEPS_PER_CYCLE chained radix-2 iterations on the held operands.
  always_comb begin
    w_acc    = acc_q;
    w_qr     = qr_q;
    w_sum    = '0;
    w_rem_sh = '0;
    w_diff   = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        // Bring in the next dividend bit; keep the difference if no borrow.
        w_rem_sh = {w_acc, w_qr[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, m_q};
        if (!w_diff[WIDTH]) begin
          w_acc = w_diff[WIDTH-1:0];
          w_qr  = {w_qr[WIDTH-2:0], 1'b1};
        end else begin
          w_acc = w_rem_sh[WIDTH-1:0];
          w_qr  = {w_qr[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Add multiplicand when the current multiplier bit is set, then shift right.
        w_sum = {1'b0, w_acc} + (w_qr[0] ? {1'b0, m_q} : '0);
        w_acc = w_sum[WIDTH:1];
        w_qr  = {w_sum[0], w_qr[WIDTH-1:1]};
      end
    end
  end

  // Operand magnitudes and the sign-corrected product used at fix-up.
  always_comb begin
    w_signed = ~op_in[0];
    w_a_mag  = (w_signed && a_in[WIDTH-1]) ? -a_in : a_in;
    w_b_mag  = (w_signed && b_in[WIDTH-1]) ? -b_in : b_in;
    w_prod   = {acc_q, qr_q};
    if (neg_lo_q) w_prod = -w_prod;
  end

  // Control FSM and next-state of all registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          is_div_d = op_in[1];
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = S_CALC;
          if (op_in[1]) begin
            qr_d     = w_a_mag;
            m_d      = w_b_mag;
            // Divide by zero keeps an all-ones quotient regardless of signs.
            neg_lo_d = w_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]) && (b_in != '0);
            neg_hi_d = w_signed && a_in[WIDTH-1];
          end else begin
            qr_d     = w_b_mag;
            m_d      = w_a_mag;
            neg_lo_d = w_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            neg_hi_d = 1'b0;
          end
`ifdef MULDIV_FAST_ZERO_EN
          // Preload the registers with what the full iteration would produce.
          if (op_in[1] && (b_in == '0)) begin
            acc_d   = w_a_mag;
            qr_d    = '1;
            state_d = S_FIX;
          end else if (!op_in[1] && ((a_in == '0) || (b_in == '0))) begin
            acc_d   = '0;
            qr_d    = '0;
            state_d = S_FIX;
          end
`endif
        end else begin
          if (hiWrite_in) hi_d = a_in;
          if (loWrite_in) lo_d = a_in;
        end
      end
      S_CALC: begin
        acc_d = w_acc;
        qr_d  = w_qr;
        cnt_d = cnt_q + c_cnt_w'(1);
        if (cnt_q == c_last) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -qr_q : qr_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy_out = (state_q != S_IDLE);
  assign done_out = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mul_div
// Description : Self-checking bench for mips_mul_div with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mul_div;
  parameter int STEPS = 1;
  localparam int N = 32 / STEPS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_in = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        hiWrite_in = 1'b0;
  logic        loWrite_in = 1'b0;
  logic [31:0] hi_out, lo_out;
  logic        busy_out, done_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t0;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  mips_mul_div #(.WIDTH(32), .STEPS_PER_CYCLE(STEPS)) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .hiWrite_in(hiWrite_in), .loWrite_in(loWrite_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit / int arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int     sa, sb, sq, sr;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a; sb = b;
        sq = sa / sb; sr = sa % sb;
        return {32'(sr), 32'(sq)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (op[1] && b == 32'h0) return 1;
    if (!op[1] && (a == 32'h0 || b == 32'h0)) return 1;
`endif
    return N + 1;
  endfunction

  // Drive one start request (optionally with MTHI/MTLO in the same cycle).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit push, input bit wr);
    exp_t e;
    logic [63:0] r;
    @(negedge clk);
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    hiWrite_in = wr; loWrite_in = wr;
    @(posedge clk);
    #1;
    start_in = 1'b0; hiWrite_in = 1'b0; loWrite_in = 1'b0;
    a_in = $urandom; b_in = $urandom;
    if (push) begin
      r = model(op, a, b);
      e.hi = r[63:32]; e.lo = r[31:0];
      e.lat = exp_lat(op, a, b); e.t0 = cyc; e.tag = tag;
      sb.push_back(e);
    end
    check({tag, "_busy_after_start"}, {63'h0, busy_out}, 64'h1);
  endtask

  // Wait for done_out, pop the scoreboard and compare results and latency.
  task automatic collect();
    exp_t e;
    bit   busy_ok = 1'b1;
    bit   seen = 1'b0;
    e = sb.pop_front();
    for (int k = 0; k < 300 && !seen; k++) begin
      if (done_out) seen = 1'b1;
      else begin
        if (!busy_out) busy_ok = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: observed no done_out expected done_out", e.tag);
    end else begin
      check({e.tag, "_hi"}, {32'h0, hi_out}, {32'h0, e.hi});
      check({e.tag, "_lo"}, {32'h0, lo_out}, {32'h0, e.lo});
      check({e.tag, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
      check({e.tag, "_busy_held"}, {63'h0, busy_ok}, 64'h1);
      check({e.tag, "_busy_clear"}, {63'h0, busy_out}, 64'h0);
    end
  endtask

  initial begin
    logic [31:0] hold;
    bit          done_seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset state.
    #2;
    check("rst_hi", {32'h0, hi_out}, 64'h0);
    check("rst_lo", {32'h0, lo_out}, 64'h0);
    check("rst_busy", {63'h0, busy_out}, 64'h0);
    check("rst_done", {63'h0, done_out}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // MTLO, then MTHI and MTLO together.
    @(negedge clk); loWrite_in = 1'b1; a_in = 32'h1234;
    @(posedge clk); #1; loWrite_in = 1'b0;
    check("mtlo", {32'h0, lo_out}, 64'h1234);
    check("mtlo_hi_untouched", {32'h0, hi_out}, 64'h0);
    @(negedge clk); loWrite_in = 1'b1; hiWrite_in = 1'b1; a_in = 32'hCAFE0001;
    @(posedge clk); #1; loWrite_in = 1'b0; hiWrite_in = 1'b0;
    check("mthi_both", {32'h0, hi_out}, 64'hCAFE0001);
    check("mtlo_both", {32'h0, lo_out}, 64'hCAFE0001);

    // Directed arithmetic cases.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1, 0); collect();
    issue(2'b00, 32'hFFFFFFFD, 32'd7, "mult_neg", 1, 0); collect();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, "div_neg", 1, 0); collect();
    issue(2'b11, 32'd100, 32'd0, "divu_zero", 1, 0); collect();
    issue(2'b10, 32'hFFFFFFFB, 32'd0, "div_zero_neg", 1, 0); collect();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1, 0); collect();
    issue(2'b00, 32'd0, 32'h12345678, "mult_zero", 1, 0); collect();

    // Start and MTHI while busy are ignored.
    hold = hi_out;
    issue(2'b01, 32'd6, 32'd7, "multu_restart", 1, 0);
    repeat (8) @(posedge clk);
    @(negedge clk); start_in = 1'b1; op_in = 2'b11; a_in = 32'd5; b_in = 32'd0;
    hiWrite_in = 1'b1;
    @(posedge clk); #1; start_in = 1'b0; hiWrite_in = 1'b0;
    check("mthi_busy_ignored", {32'h0, hi_out}, {32'h0, hold});
    collect();

    // Back-to-back: start in the done cycle.
    issue(2'b11, 32'd1000, 32'd7, "divu_b2b_a", 1, 0);
    collect();
    issue(2'b00, 32'h80000000, 32'h80000000, "mult_b2b_b", 1, 0);
    collect();

    // Start with MTLO/MTHI in the same cycle: start wins.
    hold = lo_out;
    issue(2'b01, 32'd3, 32'd5, "multu_start_wins", 1, 1);
    check("start_wins_lo_hold", {32'h0, lo_out}, {32'h0, hold});
    collect();

    // Reset mid-operation aborts with no done pulse.
    issue(2'b11, 32'd1000, 32'd7, "divu_reset", 0, 0);
    repeat (13) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy_out}, 64'h0);
    check("abort_hi", {32'h0, hi_out}, 64'h0);
    check("abort_lo", {32'h0, lo_out}, 64'h0);
    check("abort_done", {63'h0, done_out}, 64'h0);
    @(negedge clk); reset = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < N + 8; k++) begin
      @(posedge clk); #1;
      if (done_out) done_seen = 1'b1;
    end
    check("abort_no_done", {63'h0, done_seen}, 64'h0);

    // Random signed/unsigned operations.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = 32'h0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      issue(rop, ra, rb, $sformatf("rand%0d", i), 1, 0);
      collect();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
